// File: rtl/icache_dm.sv
// icache_dm: direct-mapped, read-only instruction cache.
// Hits answer on the cycle after acceptance; misses fetch the whole line as an
// in-order burst from the backing memory and then answer with the captured word.
// fence.i support comes from a single-cycle clear of every valid bit.
module icache_dm #(
  parameter int NUM_LINES  = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] im_req_addr,
  input  logic        im_req_valid,
  output logic        im_req_ready,
  output logic [63:0] im_resp_rdata,
  output logic        im_resp_valid,
  output logic [63:0] bm_req_addr,
  output logic        bm_req_valid,
  input  logic        bm_req_ready,
  input  logic [63:0] bm_resp_rdata,
  input  logic        bm_resp_valid,
  input  logic        inv_valid,
  output logic        inv_ready
);

  localparam int WB = $clog2(LINE_WORDS);
  localparam int IB = $clog2(NUM_LINES);
  localparam int TW = 64 - 3 - WB - IB;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_MISS_REQ,
    S_MISS_FILL,
    S_MISS_RESP
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic [63:3]          r_addr;
  logic [63:0]          r_data [NUM_LINES*LINE_WORDS];
  logic [TW-1:0]        r_tag  [NUM_LINES];
  logic [NUM_LINES-1:0] r_valid;
  logic [63:0]          r_rd_data;
  logic [TW-1:0]        r_rd_tag;
  logic [63:0]          r_cap;
  logic [WB-1:0]        r_beat;

  logic [WB-1:0]        w_req_word;
  logic [IB-1:0]        w_req_idx;
  logic [WB-1:0]        w_word;
  logic [IB-1:0]        w_idx;
  logic [TW-1:0]        w_tag;
  logic                 w_hit;
  logic                 w_lookup_ok;
  logic                 w_accept;
  logic                 w_inv_acc;
  logic                 w_beat_fire;
  logic                 w_last_beat;
  logic                 w_unused_addr;

  // Byte offset within a 64-bit word carries no information for fetch.
  assign w_unused_addr = ^im_req_addr[2:0];

  assign w_req_word  = im_req_addr[3 +: WB];
  assign w_req_idx   = im_req_addr[3 + WB +: IB];
  assign w_word      = r_addr[3 +: WB];
  assign w_idx       = r_addr[3 + WB +: IB];
  assign w_tag       = r_addr[3 + WB + IB +: TW];

  // Valid bits are flops, read directly in the lookup cycle; tag comes from the sync read.
  assign w_hit       = (r_state == S_LOOKUP) && r_valid[w_idx] && (r_rd_tag == w_tag);
  assign w_lookup_ok = (r_state == S_IDLE) || w_hit;
  assign w_accept    = im_req_valid && im_req_ready;
  assign w_inv_acc   = inv_valid && inv_ready;
  assign w_beat_fire = (r_state == S_MISS_FILL) && bm_resp_valid;
  assign w_last_beat = (r_beat == WB'(LINE_WORDS - 1));

  // State register; reset abandons any refill in flight.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and handshake/response outputs.
  always_comb begin
    w_state_nxt   = r_state;
    im_req_ready  = 1'b0;
    inv_ready     = 1'b0;
    im_resp_valid = 1'b0;
    im_resp_rdata = '0;
    bm_req_valid  = 1'b0;
    bm_req_addr   = '0;
    // Invalidate wins over a simultaneous fetch in the cycles that can take either.
    inv_ready     = w_lookup_ok;
    im_req_ready  = w_lookup_ok && !inv_valid;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (w_hit) begin
          im_resp_valid = 1'b1;
          im_resp_rdata = r_rd_data;
          w_state_nxt   = w_accept ? S_LOOKUP : S_IDLE;
        end else begin
          w_state_nxt   = S_MISS_REQ;
        end
      end
      S_MISS_REQ: begin
        bm_req_valid = 1'b1;
        bm_req_addr  = {w_tag, w_idx, {(WB + 3){1'b0}}};
        if (bm_req_ready) w_state_nxt = S_MISS_FILL;
      end
      S_MISS_FILL: begin
        if (w_beat_fire && w_last_beat) w_state_nxt = S_MISS_RESP;
      end
      S_MISS_RESP: begin
        im_resp_valid = 1'b1;
        im_resp_rdata = r_cap;
        w_state_nxt   = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Accepting a request launches the synchronous array read and latches the address.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_rd_data <= r_data[{w_req_idx, w_req_word}];
      r_rd_tag  <= r_tag[w_req_idx];
      r_addr    <= im_req_addr[63:3];
    end
  end

  // Refill beats land in the data array at {index, beat}.
  always_ff @(posedge clk) begin
    if (w_beat_fire) r_data[{w_idx, r_beat}] <= bm_resp_rdata;
  end

  // Tag is written with the last beat, together with the valid bit.
  always_ff @(posedge clk) begin
    if (w_beat_fire && w_last_beat) r_tag[w_idx] <= w_tag;
  end

  // Hold the requested word as it streams past so the response needs no array read.
  always_ff @(posedge clk) begin
    if (w_beat_fire && (r_beat == w_word)) r_cap <= bm_resp_rdata;
  end

  // Valid bits: cleared by reset or invalidate, set when a line completes.
  always_ff @(posedge clk) begin
    if (rst)                             r_valid <= '0;
    else if (w_inv_acc)                  r_valid <= '0;
    else if (w_beat_fire && w_last_beat) r_valid[w_idx] <= 1'b1;
  end

  // Beat counter restarts on each refill request handshake.
  always_ff @(posedge clk) begin
    if (rst)                                         r_beat <= '0;
    else if ((r_state == S_MISS_REQ) && bm_req_ready) r_beat <= '0;
    else if (w_beat_fire)                            r_beat <= r_beat + 1'b1;
  end

endmodule

// File: tb/tb_icache_dm.sv
// tb_icache_dm: directed bench for icache_dm (NUM_LINES=64, LINE_WORDS=4).
// The bench plays the backing memory cycle by cycle; refill beat data is a
// fixed function of the beat's word address.
module tb_icache_dm;

  logic        clk;
  logic        rst;
  logic [63:0] im_req_addr;
  logic        im_req_valid;
  logic        im_req_ready;
  logic [63:0] im_resp_rdata;
  logic        im_resp_valid;
  logic [63:0] bm_req_addr;
  logic        bm_req_valid;
  logic        bm_req_ready;
  logic [63:0] bm_resp_rdata;
  logic        bm_resp_valid;
  logic        inv_valid;
  logic        inv_ready;

  int passed;
  int total;
  int bm_req_cnt;

  icache_dm #(.NUM_LINES(64), .LINE_WORDS(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .im_req_addr  (im_req_addr),
    .im_req_valid (im_req_valid),
    .im_req_ready (im_req_ready),
    .im_resp_rdata(im_resp_rdata),
    .im_resp_valid(im_resp_valid),
    .bm_req_addr  (bm_req_addr),
    .bm_req_valid (bm_req_valid),
    .bm_req_ready (bm_req_ready),
    .bm_resp_rdata(bm_resp_rdata),
    .bm_resp_valid(bm_resp_valid),
    .inv_valid    (inv_valid),
    .inv_ready    (inv_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count refill request handshakes seen by the memory side.
  always @(posedge clk) begin
    if (!rst && bm_req_valid && bm_req_ready) bm_req_cnt <= bm_req_cnt + 1;
  end

  function automatic logic [63:0] data_of(input logic [63:0] a);
    return {a[31:0] ^ 32'h5A5A_C3C3, ~a[31:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    im_req_valid = 1'b0; im_req_addr = '0;
    bm_req_ready = 1'b0; bm_resp_valid = 1'b0; bm_resp_rdata = '0;
    inv_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  // Full miss sequence: accept, lookup miss, optional request stall, 4 beats, response.
  task automatic fetch_miss(input logic [63:0] a, input int stall, input string nm);
    logic [63:0] line;
    line = {a[63:5], 5'b0};
    im_req_valid = 1'b1; im_req_addr = a; #1;
    total++; if (im_req_ready !== 1'b1) $display("FAIL %s accept: im_req_ready=%b want 1", nm, im_req_ready); else passed++;
    step();
    im_req_valid = 1'b0; im_req_addr = '0; #1;
    total++; if ({im_resp_valid, im_req_ready} !== 2'b00) $display("FAIL %s lookup: resp_valid,ready=%b want 00", nm, {im_resp_valid, im_req_ready}); else passed++;
    step();
    for (int i = 0; i < stall; i++) begin
      bm_req_ready = 1'b0; #1;
      total++; if (bm_req_valid !== 1'b1 || bm_req_addr !== line || im_resp_valid !== 1'b0)
        $display("FAIL %s stall%0d: bm_valid=%b addr=%h resp_valid=%b want 1 %h 0", nm, i, bm_req_valid, bm_req_addr, im_resp_valid, line);
      else passed++;
      step();
    end
    bm_req_ready = 1'b1; #1;
    total++; if (bm_req_valid !== 1'b1 || bm_req_addr !== line) $display("FAIL %s bm_req: valid=%b addr=%h want 1 %h", nm, bm_req_valid, bm_req_addr, line); else passed++;
    total++; if ({inv_ready, im_req_ready} !== 2'b00) $display("FAIL %s miss_ready: inv,req=%b want 00", nm, {inv_ready, im_req_ready}); else passed++;
    step();
    bm_req_ready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      bm_resp_valid = 1'b1; bm_resp_rdata = data_of(line + 64'(8 * b)); #1;
      total++; if ({im_resp_valid, im_req_ready, bm_req_valid} !== 3'b000)
        $display("FAIL %s beat%0d: resp_valid,ready,bm_valid=%b want 000", nm, b, {im_resp_valid, im_req_ready, bm_req_valid});
      else passed++;
      step();
    end
    bm_resp_valid = 1'b0; bm_resp_rdata = '0; #1;
    total++; if (im_resp_valid !== 1'b1 || im_resp_rdata !== data_of({a[63:3], 3'b0}) || im_req_ready !== 1'b0)
      $display("FAIL %s resp: valid=%b data=%h ready=%b want 1 %h 0", nm, im_resp_valid, im_resp_rdata, im_req_ready, data_of({a[63:3], 3'b0}));
    else passed++;
    step();
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    total++; if ({im_req_ready, inv_ready, im_resp_valid, bm_req_valid} !== 4'b1100)
      $display("FAIL reset: req_ready,inv_ready,resp_valid,bm_valid=%b want 1100", {im_req_ready, inv_ready, im_resp_valid, bm_req_valid});
    else passed++;
    total++; if (im_resp_rdata !== 64'h0 || bm_req_addr !== 64'h0)
      $display("FAIL reset_zero: rdata=%h bm_addr=%h want 0 0", im_resp_rdata, bm_req_addr);
    else passed++;
    step();
  endtask

  task automatic test_cold_miss();
    fetch_miss(64'h8000_0000, 0, "cold");
  endtask

  task automatic test_back_to_back();
    logic [63:0] addrs [3];
    int c0;
    addrs[0] = 64'h8000_0000; addrs[1] = 64'h8000_0008; addrs[2] = 64'h8000_0010;
    apply_reset();
    fetch_miss(64'h8000_0018, 0, "crit");
    c0 = bm_req_cnt;
    for (int i = 0; i < 4; i++) begin
      im_req_valid = (i < 3); im_req_addr = (i < 3) ? addrs[i] : 64'h0; #1;
      if (i < 3) begin
        total++; if (im_req_ready !== 1'b1) $display("FAIL b2b ready%0d: im_req_ready=%b want 1", i, im_req_ready); else passed++;
      end
      if (i > 0) begin
        total++; if (im_resp_valid !== 1'b1 || im_resp_rdata !== data_of(addrs[i-1]) || bm_req_valid !== 1'b0)
          $display("FAIL b2b hit%0d: valid=%b data=%h bm_valid=%b want 1 %h 0", i - 1, im_resp_valid, im_resp_rdata, bm_req_valid, data_of(addrs[i-1]));
        else passed++;
      end
      step();
    end
    im_req_valid = 1'b0; #1;
    total++; if (bm_req_cnt !== c0 || im_resp_valid !== 1'b0)
      $display("FAIL b2b idle: refills=%0d resp_valid=%b want %0d 0", bm_req_cnt, im_resp_valid, c0);
    else passed++;
    step();
  endtask

  task automatic test_conflict();
    int c0;
    apply_reset();
    c0 = bm_req_cnt;
    fetch_miss(64'h8000_0000, 0, "conf_a");
    fetch_miss(64'h8000_0808, 0, "conf_b");
    fetch_miss(64'h8000_0000, 0, "conf_a2");
    #1;
    total++; if (bm_req_cnt !== c0 + 3) $display("FAIL conflict refills: got %0d want %0d", bm_req_cnt - c0, 3); else passed++;
    step();
  endtask

  task automatic test_invalidate();
    // Line 0x80000000 is resident from the conflict test: confirm with a hit.
    im_req_valid = 1'b1; im_req_addr = 64'h8000_0008; #1;
    step();
    im_req_valid = 1'b0; im_req_addr = '0; #1;
    total++; if (im_resp_valid !== 1'b1 || im_resp_rdata !== data_of(64'h8000_0008))
      $display("FAIL inv prehit: valid=%b data=%h want 1 %h", im_resp_valid, im_resp_rdata, data_of(64'h8000_0008));
    else passed++;
    step();
    inv_valid = 1'b1; im_req_valid = 1'b1; im_req_addr = 64'h8000_0008; #1;
    total++; if ({inv_ready, im_req_ready} !== 2'b10) $display("FAIL inv priority: inv_ready,req_ready=%b want 10", {inv_ready, im_req_ready}); else passed++;
    step();
    inv_valid = 1'b0; im_req_valid = 1'b0;
    fetch_miss(64'h8000_0008, 0, "inv_retry");
  endtask

  task automatic test_backpressure();
    apply_reset();
    fetch_miss(64'h8000_0100, 5, "bp");
  endtask

  task automatic test_reset_mid_fill();
    int c0;
    apply_reset();
    im_req_valid = 1'b1; im_req_addr = 64'h8000_0200; step();
    im_req_valid = 1'b0; im_req_addr = '0; step();
    bm_req_ready = 1'b1; #1;
    total++; if (bm_req_valid !== 1'b1 || bm_req_addr !== 64'h8000_0200)
      $display("FAIL rmf bm_req: valid=%b addr=%h want 1 80000200", bm_req_valid, bm_req_addr);
    else passed++;
    step();
    bm_req_ready = 1'b0;
    for (int b = 0; b < 2; b++) begin
      bm_resp_valid = 1'b1; bm_resp_rdata = data_of(64'h8000_0200 + 64'(8 * b)); step();
    end
    bm_resp_valid = 1'b0; bm_resp_rdata = '0;
    rst = 1'b1; step();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++; if (im_resp_valid !== 1'b0 || bm_req_valid !== 1'b0)
        $display("FAIL rmf quiet%0d: resp_valid=%b bm_valid=%b want 0 0", i, im_resp_valid, bm_req_valid);
      else passed++;
      step();
    end
    c0 = bm_req_cnt;
    fetch_miss(64'h8000_0200, 0, "rmf_refetch");
    #1;
    total++; if (bm_req_cnt !== c0 + 1) $display("FAIL rmf refill count: got %0d want 1", bm_req_cnt - c0); else passed++;
    step();
  endtask

  initial begin
    passed = 0; total = 0; bm_req_cnt = 0;
    rst = 1'b1;
    im_req_valid = 1'b0; im_req_addr = '0;
    bm_req_ready = 1'b0; bm_resp_valid = 1'b0; bm_resp_rdata = '0;
    inv_valid = 1'b0;
    test_reset();
    test_cold_miss();
    test_back_to_back();
    test_conflict();
    test_invalidate();
    test_backpressure();
    test_reset_mid_fill();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/icache_dm.md
Name: icache_dm

Overview:
- Direct-mapped, read-only instruction cache.
- Acts as the responder on the I-mem request/response interface driven by the instruction fetch pipeline.
- Sits between the fetch pipeline and the backing memory bus. Hits return in one cycle; misses refill a full line via an in-order burst, then respond.
- Provides a whole-cache invalidate for fence.i.

Parameters:
- NUM_LINES, 64, number of cache lines; power of 2.
- LINE_WORDS, 4, 64-bit words per line; power of 2, at least 2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- im_req_addr  in  64  fetch byte address; bits [2:0] ignored.
- im_req_valid  in  1  fetch request valid.
- im_req_ready  out  1  request accepted when valid && ready.
- im_resp_rdata  out  64  aligned 64-bit word containing the requested address.
- im_resp_valid  out  1  one-cycle response pulse. No backpressure.
- bm_req_addr  out  64  line-aligned refill address.
- bm_req_valid  out  1  refill request valid.
- bm_req_ready  in  1  refill request accepted when valid && ready.
- bm_resp_rdata  in  64  refill beat data.
- bm_resp_valid  in  1  refill beat valid. Beats return in ascending word order, LINE_WORDS beats per request.
- inv_valid  in  1  invalidate-all request.
- inv_ready  out  1  invalidate accepted when valid && ready.

Behaviour:
- Address split:
  - word = addr[3 +: log2(LINE_WORDS)]
  - index = next log2(NUM_LINES) bits
  - tag = remaining upper bits
- Storage:
  - Data and tag arrays use a synchronous read.
  - Valid bits are flops so that all can be cleared in one cycle.
- States: IDLE, LOOKUP, MISS_REQ, MISS_FILL, MISS_RESP.
- IDLE / LOOKUP (hit pipeline):
  - An accepted request at cycle T reads the arrays and registers the address. The following cycle is the lookup cycle.
  - At T+1, on hit (valid && tag match): im_resp_valid=1 and im_resp_rdata = the addressed word.
  - im_req_ready at T+1 is 1 on a hit, so requests can be accepted back to back, one per cycle.
  - At T+1, on miss: im_resp_valid=0 and im_req_ready=0 combinationally in that same cycle. Next state is MISS_REQ.
- im_req_ready is 1 only in these two cases:
  - IDLE with no inv_valid.
  - A lookup cycle that hits, with no inv_valid.
- MISS_REQ:
  - bm_req_valid=1 and bm_req_addr = {tag, index, zeros}.
  - bm_req_valid and bm_req_addr are held stable until bm_req_ready.
  - On handshake: go to MISS_FILL and clear the beat counter.
- MISS_FILL:
  - Each bm_resp_valid beat is written to the data array at {index, beat}, and the beat counter increments.
  - The beat whose number equals the requested word is captured into a response register.
  - On the last beat (counter = LINE_WORDS-1): write the tag, set the valid bit, and go to MISS_RESP.
  - bm_resp_valid in any other state is ignored.
- MISS_RESP:
  - im_resp_valid=1 for one cycle with the captured word.
  - im_req_ready=0 in this cycle. Go to IDLE.
- Response count:
  - Exactly one response per accepted request, in order.
  - A miss response arrives no earlier than T+1+LINE_WORDS+2.
- Invalidate:
  - inv_ready=1 only in IDLE or on a hitting lookup cycle.
  - inv_valid has priority over a simultaneous fetch request: that request is not accepted that cycle.
  - On accept, all valid bits clear at the next edge. Lookups from the next cycle onward miss.
- Refill overwrites the indexed line unconditionally (eviction without writeback).
- Outputs are 0 whenever not asserted.
- Reset:
  - State goes to IDLE, all valid bits are cleared, and the beat counter is cleared.
  - im_resp_valid=0, bm_req_valid=0, im_req_ready=1, inv_ready=1.
  - Reset mid-miss abandons the refill and issues no response. The backing memory shares rst, so no stray beats follow.

Test Plan:
- Cold miss:
  - Stimulus: after reset, fetch 0x80000000; bm_req_ready=1; beats D0..D3 returned on consecutive cycles.
  - Required response: bm_req_addr=0x80000000; im_resp_rdata=D0 one cycle after the last beat; im_req_ready=0 throughout.
- Critical word and back-to-back hits:
  - Stimulus: miss at 0x80000018; then fetch 0x80000000, 0x80000008, 0x80000010 on consecutive cycles.
  - Required response: the miss returns D3. The three hits return D0, D1, D2 on consecutive cycles, with no bm request issued.
- Conflict eviction:
  - Stimulus: fill 0x80000000; fetch 0x80000800 (same index with NUM_LINES=64, LINE_WORDS=4); then fetch 0x80000000 again.
  - Required response: each of the three fetches issues a refill.
- Invalidate:
  - Stimulus: fill a line; assert inv_valid in the same cycle as im_req_valid.
  - Required response: inv accepted and the request not accepted that cycle. The request retried next cycle misses and refills.
- Backpressure:
  - Stimulus: hold bm_req_ready=0 for 5 cycles during MISS_REQ.
  - Required response: bm_req_valid=1 with bm_req_addr stable for all 5 cycles; no im_resp_valid.
- Reset mid-fill:
  - Stimulus: assert rst after 2 beats.
  - Required response: no im_resp_valid. The next fetch of the same line misses and issues a fresh refill.
